sj_mcu_host: RTL and testbench

Host-side counterpart of the Taito SJ 68705 MCU interface, sitting between the main Z80 and the MCU block. It decodes main-CPU accesses to the MCU comm latch and status port into single-cycle `bs_wr`/`bs_rd` strobes. It also arbitrates the main bus: it converts the MCU's bus request into a Z80 BUSRQ/BUSAK exchange, and while the MCU holds the bus it steers the MCU's bus-master signals onto the shared RAM port.

---
 rtl/sj_mcu_host.sv | 194 +++++++++++++++++++
 tb/tb_sj_mcu_host.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sj_mcu_host.sv
// Host-side interface to the Taito SJ 68705 MCU: comm latch/status decode for the
// main Z80, plus BUSRQ/BUSAK arbitration that lets the MCU master the shared RAM.
module sj_mcu_host #(
    parameter logic [5:0] STAT_FILL = 6'h3f
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        comm_cs,
    input  logic        stat_cs,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        z80_busrq_n,
    input  logic        z80_busak_n,
    input  logic        mcu_busrq_n,
    output logic        mcu_busak_n,
    input  logic [15:0] bm_addr,
    input  logic [7:0]  bm_dout,
    input  logic        bm_we,
    input  logic        bm_rd,
    output logic [7:0]  bm_din,
    input  logic [7:0]  ram_din,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_dout,
    output logic        ram_we,
    output logic        ram_cs,
    output logic        bs_wr,
    output logic        bs_rd,
    output logic [7:0]  bs_dout,
    input  logic [7:0]  bs_din,
    input  logic        obf,
    input  logic        ibf
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_GRANT = 2'd2,
        ST_REL   = 2'd3
    } arb_state_t;

    arb_state_t  r_state;
    arb_state_t  w_state_nxt;

    logic        r_wr_hist;
    logic        r_rd_hist;
    logic        r_bs_wr;
    logic        r_bs_rd;
    logic [7:0]  r_bs_dout;
    logic [7:0]  r_bm_din;

    logic        w_wr_act;
    logic        w_rd_act;
    logic        w_grant;
    logic        w_z80_busrq_n;
    logic        w_mcu_busak_n;
    logic [7:0]  w_cpu_din;

    assign w_wr_act = comm_cs & cpu_wr;
    assign w_rd_act = comm_cs & cpu_rd;

    // Comm strobes: write fires on the access rising edge, read on its falling edge
    // so the MCU only sees the byte consumed after the CPU has latched it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_hist <= 1'b0;
            r_rd_hist <= 1'b0;
            r_bs_wr   <= 1'b0;
            r_bs_rd   <= 1'b0;
            r_bs_dout <= 8'h00;
        end else begin
            r_wr_hist <= w_wr_act;
            r_rd_hist <= w_rd_act;
            r_bs_wr   <= w_wr_act & ~r_wr_hist;
            r_bs_rd   <= r_rd_hist & ~w_rd_act;
            if (w_wr_act && !r_wr_hist) begin
                r_bs_dout <= cpu_dout;
            end
        end
    end

    // Arbiter state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Arbiter next state; a withdrawn request wins over a same-cycle ack so the
    // MCU is never granted a bus it no longer wants.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!mcu_busrq_n) begin
                    w_state_nxt = ST_REQ;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mcu_busrq_n) begin
                    w_state_nxt = ST_REL;
                end else if (!z80_busak_n) begin
                    w_state_nxt = ST_GRANT;
                end else begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_GRANT: begin
                if (mcu_busrq_n) begin
                    w_state_nxt = ST_REL;
                end else begin
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_REL: begin
                if (z80_busak_n) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_REL;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Bus handshake outputs decoded from the registered state only
    always_comb begin
        w_z80_busrq_n = 1'b1;
        w_mcu_busak_n = 1'b1;
        w_grant       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_z80_busrq_n = 1'b1;
            end
            ST_REQ: begin
                w_z80_busrq_n = 1'b0;
            end
            ST_GRANT: begin
                w_z80_busrq_n = 1'b0;
                w_mcu_busak_n = 1'b0;
                w_grant       = 1'b1;
            end
            ST_REL: begin
                w_z80_busrq_n = 1'b1;
            end
            default: begin
                w_z80_busrq_n = 1'b1;
            end
        endcase
    end

    // MCU read-back register: only updates on a granted read, otherwise holds
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bm_din <= 8'hff;
        end else if (w_grant && bm_rd) begin
            r_bm_din <= ram_din;
        end else begin
            r_bm_din <= r_bm_din;
        end
    end

    // Host read mux; comm latch takes priority over status
    always_comb begin
        w_cpu_din = 8'hff;
        if (comm_cs) begin
            w_cpu_din = bs_din;
        end else if (stat_cs) begin
            w_cpu_din = {STAT_FILL, obf, ~ibf};
        end else begin
            w_cpu_din = 8'hff;
        end
    end

    assign cpu_din     = w_cpu_din;
    assign z80_busrq_n = w_z80_busrq_n;
    assign mcu_busak_n = w_mcu_busak_n;
    assign ram_cs      = w_grant;
    assign ram_we      = w_grant & bm_we;
    assign ram_addr    = w_grant ? bm_addr : 16'h0000;
    assign ram_dout    = w_grant ? bm_dout : 8'h00;
    assign bm_din      = r_bm_din;
    assign bs_wr       = r_bs_wr;
    assign bs_rd       = r_bs_rd;
    assign bs_dout     = r_bs_dout;

endmodule

// File: tb/tb_sj_mcu_host.sv
// Directed self-checking bench for sj_mcu_host: comm strobes, status decode,
// bus arbitration, RAM steering and reset during grant.
module tb_sj_mcu_host;

    logic        clk = 1'b0;
    logic        rst;
    logic        comm_cs, stat_cs, cpu_rd, cpu_wr;
    logic [7:0]  cpu_dout, cpu_din;
    logic        z80_busrq_n, z80_busak_n, mcu_busrq_n, mcu_busak_n;
    logic [15:0] bm_addr, ram_addr;
    logic [7:0]  bm_dout, bm_din, ram_din, ram_dout, bs_dout, bs_din;
    logic        bm_we, bm_rd, ram_we, ram_cs, bs_wr, bs_rd, obf, ibf;

    int n_pass  = 0;
    int n_total = 0;

    sj_mcu_host #(.STAT_FILL(6'h3f)) dut (
        .clk(clk), .rst(rst),
        .comm_cs(comm_cs), .stat_cs(stat_cs), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .cpu_dout(cpu_dout), .cpu_din(cpu_din),
        .z80_busrq_n(z80_busrq_n), .z80_busak_n(z80_busak_n),
        .mcu_busrq_n(mcu_busrq_n), .mcu_busak_n(mcu_busak_n),
        .bm_addr(bm_addr), .bm_dout(bm_dout), .bm_we(bm_we), .bm_rd(bm_rd), .bm_din(bm_din),
        .ram_din(ram_din), .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_we(ram_we), .ram_cs(ram_cs),
        .bs_wr(bs_wr), .bs_rd(bs_rd), .bs_dout(bs_dout), .bs_din(bs_din),
        .obf(obf), .ibf(ibf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        comm_cs = 1'b0; stat_cs = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_dout = 8'h00;
        z80_busak_n = 1'b1; mcu_busrq_n = 1'b1;
        bm_addr = 16'h0000; bm_dout = 8'h00; bm_we = 1'b0; bm_rd = 1'b0;
        ram_din = 8'h00; bs_din = 8'h00; obf = 1'b0; ibf = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        n_total++; if ({z80_busrq_n, mcu_busak_n} !== 2'b11) $display("FAIL reset_bus got=%b exp=11", {z80_busrq_n, mcu_busak_n}); else n_pass++;
        n_total++; if (cpu_din !== 8'hff) $display("FAIL reset_cpu_din got=%h exp=ff", cpu_din); else n_pass++;
        n_total++; if ({bs_wr, bs_rd, ram_cs, ram_we} !== 4'b0000) $display("FAIL reset_strobes got=%b exp=0000", {bs_wr, bs_rd, ram_cs, ram_we}); else n_pass++;
        n_total++; if ({bs_dout, bm_din} !== 16'h00ff) $display("FAIL reset_regs got=%h exp=00ff", {bs_dout, bm_din}); else n_pass++;
    endtask

    task automatic test_comm_write();
        int pulses = 0;
        comm_cs = 1'b1; cpu_wr = 1'b1; cpu_dout = 8'h5a;
        tick();
        n_total++; if (bs_wr !== 1'b1) $display("FAIL wr_first_cycle got=%b exp=1", bs_wr); else n_pass++;
        pulses = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bs_wr === 1'b1) pulses++;
        end
        comm_cs = 1'b0; cpu_wr = 1'b0; cpu_dout = 8'h00;
        tick();
        if (bs_wr === 1'b1) pulses++;
        tick();
        if (bs_wr === 1'b1) pulses++;
        n_total++; if (pulses !== 1) $display("FAIL wr_pulse_count got=%0d exp=1", pulses); else n_pass++;
        n_total++; if (bs_dout !== 8'h5a) $display("FAIL wr_bs_dout got=%h exp=5a", bs_dout); else n_pass++;
    endtask

    task automatic test_status();
        stat_cs = 1'b1; cpu_rd = 1'b1; obf = 1'b1; ibf = 1'b0;
        #1;
        n_total++; if (cpu_din !== 8'hff) $display("FAIL stat_obf1_ibf0 got=%h exp=ff", cpu_din); else n_pass++;
        obf = 1'b0; ibf = 1'b1;
        #1;
        n_total++; if (cpu_din !== 8'hfc) $display("FAIL stat_obf0_ibf1 got=%h exp=fc", cpu_din); else n_pass++;
        obf = 1'b1; ibf = 1'b1;
        #1;
        n_total++; if (cpu_din !== 8'hfe) $display("FAIL stat_obf1_ibf1 got=%h exp=fe", cpu_din); else n_pass++;
        comm_cs = 1'b1; bs_din = 8'h81;
        #1;
        n_total++; if (cpu_din !== 8'h81) $display("FAIL comm_priority got=%h exp=81", cpu_din); else n_pass++;
        tick();
        comm_cs = 1'b0; stat_cs = 1'b0; cpu_rd = 1'b0; obf = 1'b0;
        tick(); tick();
    endtask

    task automatic test_comm_read();
        int early = 0;
        comm_cs = 1'b1; cpu_rd = 1'b1; bs_din = 8'h3c;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++; if (cpu_din !== 8'h3c) $display("FAIL rd_data got=%h exp=3c", cpu_din); else n_pass++;
            if (bs_rd !== 1'b0) early++;
        end
        n_total++; if (early !== 0) $display("FAIL rd_strobe_early got=%0d exp=0", early); else n_pass++;
        comm_cs = 1'b0; cpu_rd = 1'b0;
        tick();
        n_total++; if (bs_rd !== 1'b1) $display("FAIL rd_strobe got=%b exp=1", bs_rd); else n_pass++;
        tick();
        n_total++; if (bs_rd !== 1'b0) $display("FAIL rd_strobe_width got=%b exp=0", bs_rd); else n_pass++;
    endtask

    task automatic test_grant();
        int early = 0;
        mcu_busrq_n = 1'b0;
        tick();
        n_total++; if ({z80_busrq_n, mcu_busak_n} !== 2'b01) $display("FAIL req_state got=%b exp=01", {z80_busrq_n, mcu_busak_n}); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (mcu_busak_n !== 1'b1 || ram_cs !== 1'b0) early++;
        end
        n_total++; if (early !== 0) $display("FAIL grant_before_ack got=%0d exp=0", early); else n_pass++;
        z80_busak_n = 1'b0;
        tick();
        n_total++; if ({mcu_busak_n, ram_cs, z80_busrq_n} !== 3'b010) $display("FAIL grant got=%b exp=010", {mcu_busak_n, ram_cs, z80_busrq_n}); else n_pass++;
        bm_addr = 16'h8123; bm_dout = 8'h77; bm_we = 1'b1;
        #1;
        n_total++; if ({ram_we, ram_addr, ram_dout} !== {1'b1, 16'h8123, 8'h77}) $display("FAIL ram_write got=%b/%h/%h exp=1/8123/77", ram_we, ram_addr, ram_dout); else n_pass++;
        tick();
        bm_we = 1'b0; bm_rd = 1'b1; bm_addr = 16'h8124; ram_din = 8'ha5;
        tick();
        n_total++; if (bm_din !== 8'ha5) $display("FAIL bm_read got=%h exp=a5", bm_din); else n_pass++;
        bm_rd = 1'b0; ram_din = 8'h11;
        tick();
        n_total++; if (bm_din !== 8'ha5) $display("FAIL bm_hold got=%h exp=a5", bm_din); else n_pass++;
        mcu_busrq_n = 1'b1;
        tick();
        n_total++; if ({z80_busrq_n, mcu_busak_n, ram_cs, ram_addr} !== {3'b110, 16'h0000}) $display("FAIL release got=%b/%h exp=110/0000", {z80_busrq_n, mcu_busak_n, ram_cs}, ram_addr); else n_pass++;
        ram_din = 8'h22; bm_rd = 1'b1;
        tick();
        n_total++; if (bm_din !== 8'ha5) $display("FAIL bm_no_grant_read got=%h exp=a5", bm_din); else n_pass++;
        bm_rd = 1'b0; bm_addr = 16'h0000; bm_dout = 8'h00;
        z80_busak_n = 1'b1;
        tick(); tick();
        n_total++; if ({z80_busrq_n, mcu_busak_n} !== 2'b11) $display("FAIL back_idle got=%b exp=11", {z80_busrq_n, mcu_busak_n}); else n_pass++;
    endtask

    task automatic test_withdraw();
        int granted = 0;
        mcu_busrq_n = 1'b0;
        tick();
        mcu_busrq_n = 1'b1;
        tick();
        n_total++; if ({z80_busrq_n, mcu_busak_n} !== 2'b11) $display("FAIL withdraw_rel got=%b exp=11", {z80_busrq_n, mcu_busak_n}); else n_pass++;
        z80_busak_n = 1'b0; mcu_busrq_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (mcu_busak_n !== 1'b1 || z80_busrq_n !== 1'b1) granted++;
        end
        n_total++; if (granted !== 0) $display("FAIL rel_holds got=%0d exp=0", granted); else n_pass++;
        z80_busak_n = 1'b1;
        tick();
        n_total++; if (z80_busrq_n !== 1'b1) $display("FAIL rel_to_idle got=%b exp=1", z80_busrq_n); else n_pass++;
        tick();
        n_total++; if (z80_busrq_n !== 1'b0) $display("FAIL idle_new_req got=%b exp=0", z80_busrq_n); else n_pass++;
        mcu_busrq_n = 1'b1;
        tick(); tick();
    endtask

    task automatic test_reset_grant();
        mcu_busrq_n = 1'b0;
        tick();
        z80_busak_n = 1'b0;
        tick();
        bm_we = 1'b1; bm_addr = 16'h4000;
        #1;
        n_total++; if (ram_we !== 1'b1) $display("FAIL pre_reset_we got=%b exp=1", ram_we); else n_pass++;
        rst = 1'b1;
        tick();
        n_total++; if ({ram_we, mcu_busak_n, z80_busrq_n, ram_cs} !== 4'b0110) $display("FAIL reset_in_grant got=%b exp=0110", {ram_we, mcu_busak_n, z80_busrq_n, ram_cs}); else n_pass++;
        rst = 1'b0;
        idle_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        mcu_busrq_n = 1'b0; z80_busak_n = 1'b0;
        comm_cs = 1'b1; cpu_wr = 1'b1; cpu_dout = 8'hc3;
        tick();
        n_total++; if ({bs_wr, bs_dout, z80_busrq_n} !== {1'b1, 8'hc3, 1'b0}) $display("FAIL concurrent_wr got=%b/%h/%b exp=1/c3/0", bs_wr, bs_dout, z80_busrq_n); else n_pass++;
        cpu_wr = 1'b0;
        tick();
        n_total++; if ({bs_wr, mcu_busak_n} !== 2'b00) $display("FAIL concurrent_grant got=%b exp=00", {bs_wr, mcu_busak_n}); else n_pass++;
        cpu_wr = 1'b1; cpu_dout = 8'h96;
        tick();
        n_total++; if ({bs_wr, bs_dout} !== {1'b1, 8'h96}) $display("FAIL second_wr got=%b/%h exp=1/96", bs_wr, bs_dout); else n_pass++;
        idle_inputs();
        tick(); tick();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_comm_write();
        test_status();
        test_comm_read();
        test_grant();
        test_withdraw();
        test_reset_grant();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
